// File: rtl/reg_alu_seq_pkg.sv
// Purpose: shared types and field positions for the reg_alu instruction sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: instruction class enum, sequencer state enum, instruction field LSB positions.
package reg_alu_seq_pkg;

  typedef enum logic [1:0] {
    CLS_ALU   = 2'b00,
    CLS_LOADI = 2'b01,
    CLS_NOP   = 2'b10,  // SKIPC when REG_ALU_SEQ_SKIPC_EN is defined
    CLS_HALT  = 2'b11
  } cls_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_IMM,
    S_HALT,
    S_SKIP,
    S_SKIP_IMM
  } state_e;

  // Instruction word layout: [15:14] class, [13:12] op, [11:9] rd_a,
  // [8:6] rd_b, [5:3] wd, [2:0] unused.
  localparam int CLS_LSB = 14;
  localparam int OP_LSB  = 12;
  localparam int RDA_LSB = 9;
  localparam int RDB_LSB = 6;
  localparam int WD_LSB  = 3;

endpackage

// File: rtl/reg_alu_seq_decode.sv
// Purpose: splits an instruction word into class and operand fields.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of instr_i.
// Ports: instr_i (word in); cls_o, op_o, rd_a_o, rd_b_o, wd_o (decoded fields out).
module reg_alu_seq_decode
  import reg_alu_seq_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic [DW-1:0] instr_i,
  output cls_e          cls_o,
  output logic [1:0]    op_o,
  output logic [AW-1:0] rd_a_o,
  output logic [AW-1:0] rd_b_o,
  output logic [AW-1:0] wd_o
);

  assign cls_o  = cls_e'(instr_i[CLS_LSB +: 2]);
  assign op_o   = instr_i[OP_LSB +: 2];
  assign rd_a_o = instr_i[RDA_LSB +: AW];
  assign rd_b_o = instr_i[RDB_LSB +: AW];
  assign wd_o   = instr_i[WD_LSB +: AW];

  // Low bits carry no meaning in any class.
  logic unused_lo;
  assign unused_lo = ^instr_i[2:0];

endmodule

// File: rtl/reg_alu_seq.sv
// Purpose: decodes a valid/ready instruction stream into registered reg_alu control pins.
// Latency: one cycle; a word accepted at edge N drives the pins until edge N+1.
// Backpressure: instr_ready depends on state only; low in IDLE/HALT until start.
// Ports: clk, reset (sync, active-high), start, instr/instr_valid/instr_ready, cout (in);
//        sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in (reg_alu controls);
//        busy, halted, retired, carry_flag (status). Option macro: REG_ALU_SEQ_SKIPC_EN.
module reg_alu_seq
  import reg_alu_seq_pkg::*;
#(
  parameter int DW    = 16,
  parameter int AW    = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DW-1:0]    instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic             cout,
  output logic             sel,
  output logic             wr,
  output logic [1:0]       op,
  output logic [AW-1:0]    rd_addr_a,
  output logic [AW-1:0]    rd_addr_b,
  output logic [AW-1:0]    wr_addr,
  output logic [DW-1:0]    d_in,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] retired,
  output logic             carry_flag
);

  state_e            state_q, state_d;
  logic              sel_q, sel_d, wr_q, wr_d;
  logic [1:0]        op_q, op_d;
  logic [AW-1:0]     rda_q, rda_d, rdb_q, rdb_d, wa_q, wa_d, wd_lat_q, wd_lat_d;
  logic [DW-1:0]     din_q, din_d;
  logic [CNT_W-1:0]  ret_q, ret_d;
  logic              acc;
  logic              skip_taken;

  cls_e              cls;
  logic [1:0]        dec_op;
  logic [AW-1:0]     dec_a, dec_b, dec_wd;

  reg_alu_seq_decode #(.DW(DW), .AW(AW)) u_dec (
    .instr_i (instr),
    .cls_o   (cls),
    .op_o    (dec_op),
    .rd_a_o  (dec_a),
    .rd_b_o  (dec_b),
    .wd_o    (dec_wd)
  );

  always_comb begin
    instr_ready = 1'b0;
    case (state_q)
      S_RUN, S_IMM, S_SKIP, S_SKIP_IMM: instr_ready = 1'b1;
      default:                          instr_ready = 1'b0;
    endcase
  end

  assign acc = instr_valid & instr_ready;

`ifdef REG_ALU_SEQ_SKIPC_EN
  // While the registered ALU controls are active, reg_alu's cout belongs to
  // that operation; forwarding it lets a SKIPC right behind the ALU word see it.
  logic carry_q, carry_fwd;
  assign carry_fwd = (wr_q & sel_q) ? cout : carry_q;
  always_ff @(posedge clk) begin
    if (reset) carry_q <= 1'b0;
    else       carry_q <= carry_fwd;
  end
  assign carry_flag = carry_q;
  assign skip_taken = carry_fwd;
`else
  logic unused_cout;
  assign unused_cout = cout;
  assign carry_flag  = 1'b0;
  assign skip_taken  = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HALT: if (start) state_d = S_RUN;
      S_RUN: begin
        if (acc) begin
          case (cls)
            CLS_LOADI: state_d = S_IMM;
            CLS_NOP:   if (skip_taken) state_d = S_SKIP;
            CLS_HALT:  state_d = S_HALT;
            default:   state_d = S_RUN;
          endcase
        end
      end
      S_IMM:      if (acc) state_d = S_RUN;
      // A skipped LOADI still owns the following immediate word.
      S_SKIP:     if (acc) state_d = (cls == CLS_LOADI) ? S_SKIP_IMM : S_RUN;
      S_SKIP_IMM: if (acc) state_d = S_RUN;
      default:    state_d = S_IDLE;
    endcase
  end

  // Output / datapath next-state logic
  always_comb begin
    sel_d    = 1'b0;
    wr_d     = 1'b0;
    op_d     = op_q;
    rda_d    = rda_q;
    rdb_d    = rdb_q;
    wa_d     = wa_q;
    din_d    = din_q;
    wd_lat_d = wd_lat_q;
    ret_d    = ret_q;
    if (acc) begin
      case (state_q)
        S_RUN: begin
          // LOADI retires with its data word, not here.
          if (cls != CLS_LOADI) ret_d = ret_q + CNT_W'(1);
          if (cls == CLS_ALU) begin
            sel_d = 1'b1;
            wr_d  = 1'b1;
            op_d  = dec_op;
            rda_d = dec_a;
            rdb_d = dec_b;
            wa_d  = dec_wd;
          end else if (cls == CLS_LOADI) begin
            wd_lat_d = dec_wd;
          end
        end
        S_IMM: begin
          wr_d  = 1'b1;
          wa_d  = wd_lat_q;
          din_d = instr;
          ret_d = ret_q + CNT_W'(1);
        end
        default: ;  // skipped words leave no trace
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q    <= 1'b0;
      wr_q     <= 1'b0;
      op_q     <= '0;
      rda_q    <= '0;
      rdb_q    <= '0;
      wa_q     <= '0;
      din_q    <= '0;
      wd_lat_q <= '0;
      ret_q    <= '0;
    end else begin
      sel_q    <= sel_d;
      wr_q     <= wr_d;
      op_q     <= op_d;
      rda_q    <= rda_d;
      rdb_q    <= rdb_d;
      wa_q     <= wa_d;
      din_q    <= din_d;
      wd_lat_q <= wd_lat_d;
      ret_q    <= ret_d;
    end
  end

  assign sel       = sel_q;
  assign wr        = wr_q;
  assign op        = op_q;
  assign rd_addr_a = rda_q;
  assign rd_addr_b = rdb_q;
  assign wr_addr   = wa_q;
  assign d_in      = din_q;
  assign retired   = ret_q;
  assign busy      = (state_q == S_RUN) || (state_q == S_IMM);
  assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_reg_alu_seq.sv
module tb_reg_alu_seq;

  localparam int CW = 8;  // narrow counter keeps the wrap test short

  logic          clk = 1'b0;
  logic          reset, start, instr_valid, instr_ready, cout;
  logic [15:0]   instr, d_in;
  logic          sel, wr, busy, halted, carry_flag;
  logic [1:0]    op;
  logic [2:0]    rd_addr_a, rd_addr_b, wr_addr;
  logic [CW-1:0] retired;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reg_alu_seq #(.DW(16), .AW(3), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .cout        (cout),
    .sel         (sel),
    .wr          (wr),
    .op          (op),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .wr_addr     (wr_addr),
    .d_in        (d_in),
    .busy        (busy),
    .halted      (halted),
    .retired     (retired),
    .carry_flag  (carry_flag)
  );

  typedef struct {
    logic          vld;
    logic [15:0]   instr;
    logic          sel;
    logic          wr;
    logic [1:0]    op;
    logic [2:0]    a;
    logic [2:0]    b;
    logic [2:0]    w;
    logic [15:0]   d;
    logic [CW-1:0] ret;
  } vec_t;

  vec_t vt[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] w);
    instr       = w;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
  endtask

  initial begin
    //            vld  instr     sel wr op   a     b     w     d         ret
    vt[0] = '{1'b1, 16'h0E28, 1'b1, 1'b1, 2'd0, 3'd7, 3'd0, 3'd5, 16'h0000, 8'd1};
    vt[1] = '{1'b0, 16'h0000, 1'b0, 1'b0, 2'd0, 3'd7, 3'd0, 3'd5, 16'h0000, 8'd1};
    vt[2] = '{1'b1, 16'h4018, 1'b0, 1'b0, 2'd0, 3'd7, 3'd0, 3'd5, 16'h0000, 8'd1};
    vt[3] = '{1'b1, 16'hCDEF, 1'b0, 1'b1, 2'd0, 3'd7, 3'd0, 3'd3, 16'hCDEF, 8'd2};
    vt[4] = '{1'b1, 16'h14E0, 1'b1, 1'b1, 2'd1, 3'd2, 3'd3, 3'd4, 16'hCDEF, 8'd3};
    vt[5] = '{1'b1, 16'h8000, 1'b0, 1'b0, 2'd1, 3'd2, 3'd3, 3'd4, 16'hCDEF, 8'd4};
    vt[6] = '{1'b1, 16'h33BF, 1'b1, 1'b1, 2'd3, 3'd1, 3'd6, 3'd7, 16'hCDEF, 8'd5};
    vt[7] = '{1'b1, 16'h4000, 1'b0, 1'b0, 2'd3, 3'd1, 3'd6, 3'd7, 16'hCDEF, 8'd5};
    vt[8] = '{1'b1, 16'hC000, 1'b0, 1'b1, 2'd3, 3'd1, 3'd6, 3'd0, 16'hC000, 8'd6};
    vt[9] = '{1'b0, 16'h0000, 1'b0, 1'b0, 2'd3, 3'd1, 3'd6, 3'd0, 16'hC000, 8'd6};

    reset = 1'b1; start = 1'b0; instr_valid = 1'b0; instr = '0; cout = 1'b0;
    tick(); tick();
    chk("reset_pins", 64'({sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in}), 64'd0);
    chk("reset_status", 64'({instr_ready, busy, halted, carry_flag, retired}), 64'd0);
    reset = 1'b0;
    tick();
    chk("idle_not_ready", 64'({instr_ready, busy}), 64'd0);
    pulse_start();
    chk("run_after_start", 64'({instr_ready, busy, halted}), 64'b110);

    // Table-driven back-to-back words in RUN/IMM
    for (int i = 0; i < 10; i++) begin
      instr       = vt[i].instr;
      instr_valid = vt[i].vld;
      tick();
      instr_valid = 1'b0;
      chk($sformatf("vec%0d", i),
          64'({sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in, retired, busy}),
          64'({vt[i].sel, vt[i].wr, vt[i].op, vt[i].a, vt[i].b, vt[i].w, vt[i].d, vt[i].ret, 1'b1}));
    end

    // HALT holds the following word until start
    send(16'hC000);
    chk("halt_state", 64'({halted, instr_ready, busy, retired}), 64'({1'b1, 1'b0, 1'b0, 8'd7}));
    instr = 16'h0E28; instr_valid = 1'b1;
    tick(); tick();
    chk("halt_holds_word", 64'({wr, retired}), 64'({1'b0, 8'd7}));
    pulse_start();
    chk("start_edge_no_accept", 64'({wr, instr_ready, halted, retired}), 64'({1'b0, 1'b1, 1'b0, 8'd7}));
    tick();
    instr_valid = 1'b0;
    chk("held_word_exec", 64'({sel, wr, rd_addr_a, wr_addr, retired}),
        64'({1'b1, 1'b1, 3'd7, 3'd5, 8'd8}));
    tick();
    chk("idle_cycle_wr0", 64'({sel, wr}), 64'd0);

    // Reset in the middle of a LOADI
    send(16'h4018);
    chk("in_imm", 64'({busy, wr, retired}), 64'({1'b1, 1'b0, 8'd8}));
    reset = 1'b1; instr = 16'h1111; instr_valid = 1'b1;
    tick();
    chk("reset_in_imm", 64'({wr, sel, d_in, retired, busy, instr_ready}), 64'd0);
    reset = 1'b0;
    tick(); tick();
    chk("imm_word_refused", 64'({wr, retired, instr_ready, d_in}), 64'd0);
    instr_valid = 1'b0;
    pulse_start();

    // Reset right after an accepted word drops the pending write
    send(16'h0E28);
    chk("pending_write", 64'({wr, sel}), 64'b11);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("pending_write_dropped", 64'({wr, retired}), 64'd0);
    pulse_start();

    // Counter wrap: 255 NOPs then one more
    instr = 16'h8000; instr_valid = 1'b1;
    repeat (255) tick();
    instr_valid = 1'b0;
    chk("retired_all_ones", 64'(retired), 64'd255);
    send(16'h8000);
    chk("retired_wrap", 64'({retired, wr}), 64'd0);

`ifdef REG_ALU_SEQ_SKIPC_EN
    // ALU with carry, then SKIPC right behind it (forwarded carry)
    cout = 1'b1;
    instr = 16'h0E28; instr_valid = 1'b1;
    tick();
    instr = 16'h8000;
    tick();
    cout = 1'b0;
    chk("skipc_taken", 64'({carry_flag, wr, retired}), 64'({1'b1, 1'b0, 8'd2}));
    instr = 16'h4008;
    tick();
    chk("skipped_loadi", 64'({wr, retired}), 64'({1'b0, 8'd2}));
    instr = 16'h1234;
    tick();
    chk("skipped_imm", 64'({wr, retired, d_in, busy}), 64'({1'b0, 8'd2, 16'h0000, 1'b1}));
    instr = 16'h14E0;
    tick();
    instr_valid = 1'b0;
    chk("after_skip_alu", 64'({sel, wr, op, wr_addr, retired}), 64'({1'b1, 1'b1, 2'd1, 3'd4, 8'd3}));
`else
    // Without the option class 10 is a plain NOP and carry is never latched
    cout = 1'b1;
    instr = 16'h0E28; instr_valid = 1'b1;
    tick();
    instr = 16'h8000;
    tick();
    cout = 1'b0;
    chk("nop_no_carry", 64'({carry_flag, wr, retired}), 64'({1'b0, 1'b0, 8'd2}));
    instr = 16'h4008;
    tick();
    chk("loadi_after_nop", 64'({wr, retired}), 64'({1'b0, 8'd2}));
    instr = 16'h1234;
    tick();
    instr_valid = 1'b0;
    chk("imm_after_nop", 64'({sel, wr, wr_addr, d_in, retired}),
        64'({1'b0, 1'b1, 3'd1, 16'h1234, 8'd3}));
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
